ultrasonic_sequencer: RTL and testbench

Measurement sequencer for the ultrasonic ranging path. It fires the sensor trigger, times the echo pulse in prescaled ticks, and hands the 8-bit tick count to the divisor block. It holds the divisor's count and calculate inputs stable, captures the quotient as a distance, and returns to idle after a sensor recovery gap. It sits between the sensor pins and the divisor, in the CLKOUTD domain.

---
 rtl/ultrasonic_pkg.sv | 18 +
 rtl/ultrasonic_tick_gen.sv | 34 +++
 rtl/ultrasonic_sequencer.sv | 158 +++++++++++++++
 tb/tb_ultrasonic_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging path.
//   COUNT_W : width of the echo tick count handed to the divisor
//   state_e : sequencer state encoding
package ultrasonic_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_CALC,
    S_WAIT_DIV,
    S_GAP
  } state_e;

endpackage

// File: rtl/ultrasonic_tick_gen.sv
// Echo-tick prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
//   clk, rst_n : clock, async active-low reset
//   en         : prescaler runs while high, held at zero otherwise
//   restart    : zero the prescaler so the next cycle starts a fresh period
//   tick       : high on the last cycle of each period
module ultrasonic_tick_gen #(
  parameter int TICK_DIV = 58
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  // Not gated by restart: a tick on the cycle that leaves a state still counts.
  assign tick = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || !en || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ultrasonic_sequencer.sv
// Ultrasonic measurement sequencer: trigger, echo timing, divisor handshake,
// recovery gap.
//   CLKOUTD, reset          : clock, async active-low reset
//   start, auto_mode        : one-shot request / continuous re-arm after gap
//   echo                    : raw sensor echo (synchronised here)
//   trig                    : sensor trigger pulse
//   div_count/div_calculate : operand and start level to the divisor
//   div_result/div_done     : divisor quotient and its valid flag
//   distance/valid          : last good quotient, 1-cycle update pulse
//   busy, err_timeout       : not idle / 1-cycle pulse on any timeout
module ultrasonic_sequencer
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES   = 10,
  parameter int TICK_DIV      = 58,
  parameter int ECHO_WAIT_MAX = 255,
  parameter int DIV_WAIT_MAX  = 64,
  parameter int GAP_CYCLES    = 100
) (
  input  logic               CLKOUTD,
  input  logic               reset,
  input  logic               start,
  input  logic               auto_mode,
  input  logic               echo,
  output logic               trig,
  output logic [COUNT_W-1:0] div_count,
  output logic               div_calculate,
  input  logic [COUNT_W-1:0] div_result,
  input  logic               div_done,
  output logic [COUNT_W-1:0] distance,
  output logic               valid,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << COUNT_W) - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 echo_s1_q, echo_s2_q, echo_d_q;
  logic                 trig_q, trig_d;
  logic [COUNT_W-1:0]   div_count_q, div_count_d;
  logic                 div_calc_q, div_calc_d;
  logic [COUNT_W-1:0]   distance_q, distance_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 tick, rise, fall, inc;

  assign rise = echo_s2_q & ~echo_d_q;
  assign fall = ~echo_s2_q & echo_d_q;
  // Echo was high during this tick; includes the falling-edge cycle.
  assign inc  = tick & (echo_s2_q | fall);

  ultrasonic_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (CLKOUTD),
    .rst_n   (reset),
    .en      ((state_q == S_WAIT_ECHO) || (state_q == S_MEASURE)),
    .restart (state_d != state_q),
    .tick    (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    div_count_d = div_count_q;
    div_calc_d  = div_calc_q;
    distance_d  = distance_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_TRIG;
      S_TRIG: if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) state_d = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        cnt_d = cnt_q;
        if (rise) state_d = S_MEASURE;
        else if (tick) begin
          if (cnt_q == CNT_W'(ECHO_WAIT_MAX - 1)) begin
            err_d   = 1'b1;
            state_d = S_GAP;
          end else cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_q;
        if (inc && cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = S_GAP;
        end else if (fall) begin
          div_count_d = cnt_q[COUNT_W-1:0] + COUNT_W'(inc);
          state_d     = S_CALC;
        end else if (inc) cnt_d = cnt_q + 1'b1;
      end
      S_CALC: begin
        div_calc_d = 1'b1;
        state_d    = S_WAIT_DIV;
      end
      S_WAIT_DIV: begin
        if (div_done) begin
          distance_d = div_result;
          valid_d    = 1'b1;
          div_calc_d = 1'b0;
          state_d    = S_GAP;
        end else if (cnt_q == CNT_W'(DIV_WAIT_MAX - 1)) begin
          div_calc_d = 1'b0;
          err_d      = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = auto_mode ? S_TRIG : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Every state measures its own dwell from zero.
    if (state_d != state_q) cnt_d = '0;
    trig_d = (state_d == S_TRIG);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLKOUTD or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_d_q    <= 1'b0;
      trig_q      <= 1'b0;
      div_count_q <= '0;
      div_calc_q  <= 1'b0;
      distance_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      echo_s1_q   <= echo;
      echo_s2_q   <= echo_s1_q;
      echo_d_q    <= echo_s2_q;
      trig_q      <= trig_d;
      div_count_q <= div_count_d;
      div_calc_q  <= div_calc_d;
      distance_q  <= distance_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign trig          = trig_q;
  assign div_count     = div_count_q;
  assign div_calculate = div_calc_q;
  assign distance      = distance_q;
  assign valid         = valid_q;
  assign busy          = busy_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_ultrasonic_sequencer.sv
// Directed bench for ultrasonic_sequencer with a small divisor model
// (done 3 cycles into calculate, result = count >> 1).
module tb_ultrasonic_sequencer;

  logic       gclk = 1'b0, grst_n = 1'b0;
  logic       start = 1'b0, auto_mode = 1'b0, echo = 1'b0, hang = 1'b0;
  logic       trig, div_calc, div_done, valid, busy, err;
  logic [7:0] div_count, div_result, distance;

  int checks = 0, failures = 0;
  int trig_run = 0, trig_last = 0, valid_n = 0, err_n = 0, calc_n = 0;
  int dcnt = 0;
  int n, v0, e0, c0;

  always #5 gclk = ~gclk;

  ultrasonic_sequencer #(
    .TRIG_CYCLES(10), .TICK_DIV(4), .ECHO_WAIT_MAX(20), .DIV_WAIT_MAX(8), .GAP_CYCLES(5)
  ) dut (
    .CLKOUTD(gclk), .reset(grst_n), .start(start), .auto_mode(auto_mode), .echo(echo),
    .trig(trig), .div_count(div_count), .div_calculate(div_calc), .div_result(div_result),
    .div_done(div_done), .distance(distance), .valid(valid), .busy(busy), .err_timeout(err)
  );

  // Divisor model
  assign div_result = div_count >> 1;
  assign div_done   = div_calc && (dcnt == 2) && !hang;
  always @(posedge gclk) dcnt <= div_calc ? dcnt + 1 : 0;

  // Activity monitor
  always @(negedge gclk) begin
    if (trig) trig_run <= trig_run + 1;
    else if (trig_run != 0) begin
      trig_last <= trig_run;
      trig_run  <= 0;
    end
    valid_n <= valid_n + int'(valid);
    err_n   <= err_n + int'(err);
    calc_n  <= calc_n + int'(div_calc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge gclk);
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return trig;
      1:       return valid;
      2:       return err;
      default: return busy;
    endcase
  endfunction

  // Bounded wait for a signal to reach a level; n = negedges waited.
  task automatic wait_for(input string tag, input int w, input logic val, input int max,
                          output int k);
    k = 0;
    while (sel(w) !== val && k < max) begin
      @(negedge gclk);
      k++;
    end
    chk(tag, 32'(sel(w)), 32'(val));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge gclk);
    start = 1'b0;
  endtask

  task automatic send_echo(input int k);
    echo = 1'b1;
    cyc(k);
    echo = 1'b0;
  endtask

  task automatic snap;
    v0 = valid_n;
    e0 = err_n;
    c0 = calc_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exhausted");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_cnt", 32'(div_count), 0);
    chk("rst_calc", 32'(div_calc), 0);
    chk("rst_dist", 32'(distance), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    grst_n = 1'b1;
    cyc(2);
    chk("idle_busy", 32'(busy), 0);

    // Normal measurement: 172-cycle echo -> 43 ticks, distance 21
    snap();
    pulse_start();
    chk("trig_rise", 32'(trig), 1);
    wait_for("trig_fall", 0, 1'b0, 20, n);
    send_echo(172);
    wait_for("n_valid", 1, 1'b1, 60, n);
    chk("n_count", 32'(div_count), 43);
    chk("n_dist", 32'(distance), 21);
    chk("n_calc_off", 32'(div_calc), 0);
    wait_for("n_busy_low", 3, 1'b0, 20, n);
    chk("n_gap_len", n, 5);
    cyc(2);
    chk("n_trig_w", trig_last, 10);
    chk("n_valid_n", valid_n - v0, 1);
    chk("n_calc_cyc", calc_n - c0, 3);
    chk("n_err_n", err_n - e0, 0);

    // No echo: timeout 80 cycles into WAIT_ECHO
    snap();
    pulse_start();
    wait_for("ne_err", 2, 1'b1, 200, n);
    chk("ne_lat", n, 90);
    wait_for("ne_busy_low", 3, 1'b0, 20, n);
    chk("ne_gap_len", n, 5);
    cyc(2);
    chk("ne_dist", 32'(distance), 21);
    chk("ne_valid_n", valid_n - v0, 0);
    chk("ne_err_n", err_n - e0, 1);

    // Stuck echo: counter overflow after 256 ticks
    snap();
    pulse_start();
    wait_for("se_trig_fall", 0, 1'b0, 20, n);
    echo = 1'b1;
    wait_for("se_err", 2, 1'b1, 1200, n);
    chk("se_lat", n, 1027);
    echo = 1'b0;
    wait_for("se_busy_low", 3, 1'b0, 20, n);
    cyc(2);
    chk("se_calc_cyc", calc_n - c0, 0);
    chk("se_count", 32'(div_count), 43);
    chk("se_valid_n", valid_n - v0, 0);
    chk("se_err_n", err_n - e0, 1);

    // Divisor hang: calculate held 8 cycles then timeout
    hang = 1'b1;
    snap();
    pulse_start();
    wait_for("dh_trig_fall", 0, 1'b0, 20, n);
    send_echo(40);
    wait_for("dh_err", 2, 1'b1, 100, n);
    chk("dh_calc_off", 32'(div_calc), 0);
    chk("dh_count", 32'(div_count), 10);
    chk("dh_dist", 32'(distance), 21);
    cyc(2);
    chk("dh_calc_cyc", calc_n - c0, 8);
    chk("dh_valid_n", valid_n - v0, 0);
    hang = 1'b0;
    wait_for("dh_busy_low", 3, 1'b0, 20, n);

    // Auto mode: three back-to-back measurements, start in GAP ignored
    auto_mode = 1'b1;
    snap();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      wait_for("am_trig_fall", 0, 1'b0, 20, n);
      send_echo(40);
      wait_for("am_valid", 1, 1'b1, 60, n);
      chk("am_count", 32'(div_count), 10);
      chk("am_dist", 32'(distance), 5);
      if (i == 2) auto_mode = 1'b0;
      pulse_start();
      if (i < 2) begin
        wait_for("am_retrig", 0, 1'b1, 20, n);
        chk("am_retrig_lat", n + 1, 5);
      end else begin
        wait_for("am_busy_low", 3, 1'b0, 20, n);
        chk("am_idle_lat", n + 1, 5);
      end
    end
    cyc(20);
    chk("am_no_trig", 32'(trig), 0);
    chk("am_idle", 32'(busy), 0);
    chk("am_valid_n", valid_n - v0, 3);
    chk("am_err_n", err_n - e0, 0);

    // Reset during trigger and during MEASURE
    pulse_start();
    cyc(3);
    #2 grst_n = 1'b0;
    #1;
    chk("rt_trig", 32'(trig), 0);
    chk("rt_busy", 32'(busy), 0);
    chk("rt_dist", 32'(distance), 0);
    @(negedge gclk);
    grst_n = 1'b1;
    cyc(2);
    pulse_start();
    wait_for("rm_trig_fall", 0, 1'b0, 20, n);
    echo = 1'b1;
    cyc(20);
    chk("rm_busy_pre", 32'(busy), 1);
    #2 grst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_count", 32'(div_count), 0);
    chk("rm_calc", 32'(div_calc), 0);
    chk("rm_trig", 32'(trig), 0);
    echo = 1'b0;
    @(negedge gclk);
    grst_n = 1'b1;
    cyc(3);
    chk("rm_idle", 32'(busy), 0);
    snap();
    pulse_start();
    wait_for("ra_trig_fall", 0, 1'b0, 20, n);
    send_echo(40);
    wait_for("ra_valid", 1, 1'b1, 60, n);
    chk("ra_count", 32'(div_count), 10);
    chk("ra_dist", 32'(distance), 5);
    wait_for("ra_busy_low", 3, 1'b0, 20, n);
    cyc(2);
    chk("ra_valid_n", valid_n - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
